// File: rtl/rob_pkg.sv
// Shared types, widths and helpers for the multi-lane reorder buffer.
package rob_pkg;

    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned DataWidth    = 32;
    localparam int unsigned RobDepth     = 8;

    typedef struct packed {
        logic                    busy;
        logic                    done;
        logic                    exc;
        logic [RegAddrWidth-1:0] rd;
        logic [AddrWidth-1:0]    pc;
        logic [DataWidth-1:0]    data;
    } rob_entry_t;

    // Number of set bits; callers zero-extend narrower masks.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_multiport_if.sv
// Dispatch, writeback, commit and flush bundle of the reorder buffer.
interface rob_multiport_if #(
    parameter int unsigned ADDR      = 32,
    parameter int unsigned DATA      = 32,
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned DISP_W    = 2,
    parameter int unsigned WB_PORTS  = 2,
    parameter int unsigned COMMIT_W  = 2
);
    localparam int unsigned ROB = $clog2(ROB_DEPTH);

    logic [DISP_W-1:0]        alloc_valid;
    logic [5*DISP_W-1:0]      alloc_rd;
    logic [ADDR*DISP_W-1:0]   alloc_pc;
    logic                     alloc_ready;
    logic [ROB*DISP_W-1:0]    alloc_tag;

    logic [WB_PORTS-1:0]      wb_valid;
    logic [ROB*WB_PORTS-1:0]  wb_tag;
    logic [DATA*WB_PORTS-1:0] wb_data;
    logic [WB_PORTS-1:0]      wb_exc;

    logic [COMMIT_W-1:0]      commit_valid;
    logic [5*COMMIT_W-1:0]    commit_rd;
    logic [DATA*COMMIT_W-1:0] commit_data;
    logic                     commit_ready;

    logic                     ext_flush;
    logic                     flush;
    logic [ADDR-1:0]          flush_pc;

    logic [ROB:0]             count;
    logic                     empty;
    logic                     full;

    modport master (
        output alloc_valid, alloc_rd, alloc_pc,
        output wb_valid, wb_tag, wb_data, wb_exc,
        output commit_ready, ext_flush,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_rd, commit_data,
        input  flush, flush_pc, count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_pc,
        input  wb_valid, wb_tag, wb_data, wb_exc,
        input  commit_ready, ext_flush,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_rd, commit_data,
        output flush, flush_pc, count, empty, full
    );

endinterface

// File: rtl/rob_lane_pick.sv
// Prefix logic: compacted allocation tags and contiguous commit-lane mask.
module rob_lane_pick
    import rob_pkg::*;
#(
    parameter int unsigned DISP_W   = 2,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned ROB      = 3
) (
    input  logic [ROB-1:0]        tail_idx,
    input  logic [DISP_W-1:0]     alloc_valid,
    input  logic [COMMIT_W-1:0]   commit_ok,
    output logic [ROB*DISP_W-1:0] alloc_tag,
    output logic [COMMIT_W-1:0]   commit_mask
);

    // Lane i gets tail plus the number of valid lanes below it.
    always_comb begin
        logic [DISP_W-1:0] lower;
        alloc_tag = '0;
        for (int unsigned i = 0; i < DISP_W; i++) begin
            lower = '0;
            for (int unsigned j = 0; j < i; j++) begin
                lower[j] = alloc_valid[j];
            end
            alloc_tag[i*ROB +: ROB] = tail_idx + ROB'(popcount(32'(lower)));
        end
    end

    // A commit lane survives only if every older lane is also retiring.
    always_comb begin
        logic run;
        run         = 1'b1;
        commit_mask = '0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            run            = run & commit_ok[k];
            commit_mask[k] = run;
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Multi-lane reorder buffer: in-order allocate, out-of-order writeback,
// in-order multi-lane retire, precise-exception and external flush.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int unsigned ADDR      = AddrWidth,
    parameter int unsigned DATA      = DataWidth,
    parameter int unsigned ROB_DEPTH = RobDepth,
    parameter int unsigned DISP_W    = 2,
    parameter int unsigned WB_PORTS  = 2,
    parameter int unsigned COMMIT_W  = 2
) (
    input  logic           clk,
    input  logic           reset_,
    rob_multiport_if.slave bus
);

    localparam int unsigned ROB = $clog2(ROB_DEPTH);
    localparam int unsigned PW  = ROB + 1;

    rob_entry_t            ent [ROB_DEPTH];
    logic [ROB:0]          head;
    logic [ROB:0]          tail;
    logic [ROB:0]          count;
    logic [ROB:0]          free_slots;
    logic [ROB:0]          nalloc;
    logic [ROB:0]          ncommit;
    logic [ROB-1:0]        head_idx;
    logic [ROB-1:0]        tail_idx;
    logic                  flush_q;
    logic [ADDR-1:0]       flush_pc_q;
    logic [COMMIT_W-1:0]   commit_ok;
    logic [COMMIT_W-1:0]   commit_mask;
    logic [ROB*DISP_W-1:0] alloc_tag;
    logic                  alloc_fire;
    logic                  exc_head;

    assign head_idx   = head[ROB-1:0];
    assign tail_idx   = tail[ROB-1:0];
    assign count      = tail - head;
    assign free_slots = PW'(ROB_DEPTH) - count;

    assign bus.alloc_ready  = free_slots >= PW'(DISP_W);
    assign bus.alloc_tag    = alloc_tag;
    assign bus.commit_valid = commit_mask;
    assign bus.flush        = flush_q;
    assign bus.flush_pc     = flush_pc_q;
    assign bus.count        = count;
    assign bus.empty        = (count == '0);
    assign bus.full         = (head[ROB] != tail[ROB]) && (head_idx == tail_idx);

    // The cycle that shows the flush pulse drops allocation as well.
    assign alloc_fire = bus.alloc_ready && (|bus.alloc_valid) && !flush_q;
    assign nalloc     = alloc_fire ? PW'(popcount(32'(bus.alloc_valid))) : '0;
    assign ncommit    = bus.commit_ready ? PW'(popcount(32'(commit_mask))) : '0;
    assign exc_head   = ent[head_idx].busy && ent[head_idx].done && ent[head_idx].exc;

    rob_lane_pick #(
        .DISP_W  (DISP_W),
        .COMMIT_W(COMMIT_W),
        .ROB     (ROB)
    ) u_lane_pick (
        .tail_idx   (tail_idx),
        .alloc_valid(bus.alloc_valid),
        .commit_ok  (commit_ok),
        .alloc_tag  (alloc_tag),
        .commit_mask(commit_mask)
    );

    // Per-lane retire eligibility and commit payload from the entries at head.
    always_comb begin
        rob_entry_t e;
        commit_ok       = '0;
        bus.commit_rd   = '0;
        bus.commit_data = '0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            e            = ent[head_idx + ROB'(k)];
            commit_ok[k] = e.busy && e.done && !e.exc;
            bus.commit_rd[k*RegAddrWidth +: RegAddrWidth] = e.rd;
            bus.commit_data[k*DATA +: DATA]               = DATA'(e.data);
        end
    end

    // Pointer, entry and flush state; external flush outranks exception flush.
    always_ff @(posedge clk) begin
        if (reset_ || bus.ext_flush || exc_head) begin
            head <= '0;
            tail <= '0;
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                ent[i].busy <= 1'b0;
                ent[i].done <= 1'b0;
                ent[i].exc  <= 1'b0;
            end
            if (reset_) begin
                flush_q    <= 1'b0;
                flush_pc_q <= '0;
            end else if (bus.ext_flush) begin
                flush_q    <= 1'b1;
                flush_pc_q <= '0;
            end else begin
                flush_q    <= 1'b1;
                flush_pc_q <= ADDR'(ent[head_idx].pc);
            end
        end else begin
            flush_q <= 1'b0;
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_valid[p] && ent[bus.wb_tag[p*ROB +: ROB]].busy) begin
                    ent[bus.wb_tag[p*ROB +: ROB]].done <= 1'b1;
                    ent[bus.wb_tag[p*ROB +: ROB]].exc  <= bus.wb_exc[p];
                    ent[bus.wb_tag[p*ROB +: ROB]].data <= DataWidth'(bus.wb_data[p*DATA +: DATA]);
                end
            end
            if (bus.commit_ready) begin
                for (int unsigned k = 0; k < COMMIT_W; k++) begin
                    if (commit_mask[k]) begin
                        ent[head_idx + ROB'(k)].busy <= 1'b0;
                    end
                end
            end
            for (int unsigned i = 0; i < DISP_W; i++) begin
                if (alloc_fire && bus.alloc_valid[i]) begin
                    ent[alloc_tag[i*ROB +: ROB]] <= '{
                        busy: 1'b1,
                        done: 1'b0,
                        exc:  1'b0,
                        rd:   bus.alloc_rd[i*RegAddrWidth +: RegAddrWidth],
                        pc:   AddrWidth'(bus.alloc_pc[i*ADDR +: ADDR]),
                        data: '0
                    };
                end
            end
            head <= head + ncommit;
            tail <= tail + nalloc;
        end
    end

    // Two writeback ports hitting one tag in the same cycle is an upstream bug.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                for (int unsigned q = p + 1; q < WB_PORTS; q++) begin
                    assert (!(bus.wb_valid[p] && bus.wb_valid[q] &&
                              bus.wb_tag[p*ROB +: ROB] == bus.wb_tag[q*ROB +: ROB]));
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the ROB.
module tb_rob_multiport;

    logic clk;
    logic reset_;

    rob_multiport_if #(
        .ADDR(32), .DATA(32), .ROB_DEPTH(8),
        .DISP_W(2), .WB_PORTS(2), .COMMIT_W(2)
    ) bus ();

    rob_multiport #(
        .ADDR(32), .DATA(32), .ROB_DEPTH(8),
        .DISP_W(2), .WB_PORTS(2), .COMMIT_W(2)
    ) dut (
        .clk   (clk),
        .reset_(reset_),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        done;
        logic        exc;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    int          next_tag;
    logic        m_flush;
    logic [31:0] m_fpc;

    int          e_count;
    logic        e_ready;
    logic [1:0]  e_cv;
    logic [4:0]  e_rd [2];
    logic [31:0] e_data [2];
    int          e_tag [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic drive_idle();
        bus.alloc_valid  = '0;
        bus.alloc_rd     = '0;
        bus.alloc_pc     = '0;
        bus.wb_valid     = '0;
        bus.wb_tag       = '0;
        bus.wb_data      = '0;
        bus.wb_exc       = '0;
        bus.commit_ready = 1'b0;
        bus.ext_flush    = 1'b0;
    endtask

    task automatic set_alloc(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                             input logic [31:0] pc0, input logic [31:0] pc1);
        bus.alloc_valid = v;
        bus.alloc_rd    = {rd1, rd0};
        bus.alloc_pc    = {pc1, pc0};
    endtask

    task automatic set_wb(input logic [1:0] v, input int t0, input int t1,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] x);
        bus.wb_valid = v;
        bus.wb_tag   = {3'(t1), 3'(t0)};
        bus.wb_data  = {d1, d0};
        bus.wb_exc   = x;
    endtask

    // Reference behaviour at a clock edge, expressed on an ordered list of live entries.
    task automatic model_edge();
        int    nc;
        int    sz0;
        logic  pf;
        ment_t e;
        if (reset_) begin
            mq.delete(); next_tag = 0; m_flush = 1'b0; m_fpc = '0;
            return;
        end
        if (bus.ext_flush) begin
            mq.delete(); next_tag = 0; m_flush = 1'b1; m_fpc = '0;
            return;
        end
        if (mq.size() > 0 && mq[0].done && mq[0].exc) begin
            m_fpc = mq[0].pc; mq.delete(); next_tag = 0; m_flush = 1'b1;
            return;
        end
        pf = m_flush;
        m_flush = 1'b0;
        sz0 = mq.size();
        nc = 0;
        if (bus.commit_ready) begin
            while (nc < 2 && nc < mq.size() && mq[nc].done && !mq[nc].exc) nc++;
        end
        for (int p = 0; p < 2; p++) begin
            if (bus.wb_valid[p]) begin
                for (int j = 0; j < mq.size(); j++) begin
                    if (mq[j].tag == int'(bus.wb_tag[p*3 +: 3])) begin
                        e = mq[j];
                        e.done = 1'b1;
                        e.exc  = bus.wb_exc[p];
                        e.data = bus.wb_data[p*32 +: 32];
                        mq[j] = e;
                    end
                end
            end
        end
        repeat (nc) void'(mq.pop_front());
        if (!pf && (8 - sz0) >= 2) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.alloc_valid[i]) begin
                    e.tag  = next_tag;
                    e.rd   = bus.alloc_rd[i*5 +: 5];
                    e.pc   = bus.alloc_pc[i*32 +: 32];
                    e.done = 1'b0;
                    e.exc  = 1'b0;
                    e.data = '0;
                    mq.push_back(e);
                    next_tag = (next_tag + 1) % 8;
                end
            end
        end
    endtask

    // Expected outputs for the current model state and current inputs.
    task automatic predict();
        int n;
        e_count = mq.size();
        e_ready = (8 - e_count) >= 2;
        e_cv    = '0;
        for (int k = 0; k < 2; k++) begin
            e_rd[k]   = '0;
            e_data[k] = '0;
            if (k < mq.size() && mq[k].done && !mq[k].exc && (k == 0 || e_cv[0])) begin
                e_cv[k]   = 1'b1;
                e_rd[k]   = mq[k].rd;
                e_data[k] = mq[k].data;
            end
        end
        n = 0;
        for (int i = 0; i < 2; i++) begin
            e_tag[i] = (next_tag + n) % 8;
            if (bus.alloc_valid[i]) n++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic do_reset();
        drive_idle();
        reset_ = 1'b1;
        tick();
        reset_ = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.alloc_ready); end
        n_cmp++; if (bus.commit_valid !== 2'b00) begin n_bad++; $display("FAIL reset_cv: got %b want 00", bus.commit_valid); end
        n_cmp++; if (bus.flush !== 1'b0 || bus.flush_pc !== 32'h0) begin n_bad++; $display("FAIL reset_flush: got %b/%h want 0/0", bus.flush, bus.flush_pc); end
        n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        tick();
        settle();
        n_cmp++; if (bus.count !== 4'd0 || bus.commit_valid !== 2'b00) begin n_bad++; $display("FAIL idle_state: got %0d/%b want 0/00", bus.count, bus.commit_valid); end
    endtask

    task automatic test_compaction();
        do_reset();
        set_alloc(2'b10, 5'd0, 5'd9, 32'h0, 32'h200);
        settle();
        n_cmp++; if (bus.alloc_tag[5:3] !== 3'd0 || e_tag[1] != 0) begin n_bad++; $display("FAIL compact_lane1: got %0d want 0", bus.alloc_tag[5:3]); end
        tick();
        set_alloc(2'b11, 5'd10, 5'd11, 32'h204, 32'h208);
        settle();
        n_cmp++; if (bus.alloc_tag[2:0] !== 3'(e_tag[0]) || bus.alloc_tag[5:3] !== 3'(e_tag[1]))
            begin n_bad++; $display("FAIL compact_tags: got %0d,%0d want %0d,%0d", bus.alloc_tag[2:0], bus.alloc_tag[5:3], e_tag[0], e_tag[1]); end
        n_cmp++; if (bus.alloc_tag[2:0] !== 3'd1 || bus.alloc_tag[5:3] !== 3'd2)
            begin n_bad++; $display("FAIL compact_tags_abs: got %0d,%0d want 1,2", bus.alloc_tag[2:0], bus.alloc_tag[5:3]); end
        tick();
        drive_idle();
        settle();
        n_cmp++; if (bus.count !== 4'd3) begin n_bad++; $display("FAIL compact_count: got %0d want 3", bus.count); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_alloc(2'b11, 5'(2*c), 5'(2*c+1), 32'(c*8), 32'(c*8+4));
            tick();
            drive_idle();
            settle();
            n_cmp++; if (int'(bus.count) != e_count || e_count != 2*(c+1))
                begin n_bad++; $display("FAIL fill_count%0d: got %0d want %0d", c, bus.count, 2*(c+1)); end
        end
        n_cmp++; if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0)
            begin n_bad++; $display("FAIL fill_full: got full=%b ready=%b want 1/0", bus.full, bus.alloc_ready); end
        set_alloc(2'b11, 5'd30, 5'd31, 32'h900, 32'h904);
        tick();
        drive_idle();
        settle();
        n_cmp++; if (bus.count !== 4'd8 || bus.full !== 1'b1)
            begin n_bad++; $display("FAIL fill_ignored: got %0d/%b want 8/1", bus.count, bus.full); end
    endtask

    task automatic test_ooo_retire();
        do_reset();
        set_alloc(2'b11, 5'd3, 5'd4, 32'h40, 32'h44);
        tick();
        drive_idle();
        bus.commit_ready = 1'b1;
        set_wb(2'b01, 1, 0, 32'hAAAA_0001, 32'h0, 2'b00);
        tick();
        drive_idle();
        bus.commit_ready = 1'b1;
        settle();
        n_cmp++; if (bus.commit_valid !== 2'b00) begin n_bad++; $display("FAIL ooo_blocked: got %b want 00", bus.commit_valid); end
        set_wb(2'b10, 0, 0, 32'h0, 32'hBBBB_0000, 2'b00);
        tick();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            settle();
            n_cmp++; if (bus.commit_valid !== e_cv || e_cv !== 2'b11 || bus.count !== 4'd2)
                begin n_bad++; $display("FAIL ooo_hold%0d: got cv=%b cnt=%0d want 11/2", c, bus.commit_valid, bus.count); end
            n_cmp++; if (bus.commit_rd !== {e_rd[1], e_rd[0]} || bus.commit_rd !== {5'd4, 5'd3} ||
                         bus.commit_data !== {32'hAAAA_0001, 32'hBBBB_0000})
                begin n_bad++; $display("FAIL ooo_payload%0d: got %h/%h want rd 4,3", c, bus.commit_rd, bus.commit_data); end
            if (c < 2) tick();
        end
        bus.commit_ready = 1'b1;
        tick();
        drive_idle();
        settle();
        n_cmp++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL ooo_drained: got %0d want 0", bus.count); end
    endtask

    task automatic test_exception();
        do_reset();
        set_alloc(2'b11, 5'd1, 5'd2, 32'h100, 32'h104);
        tick();
        set_alloc(2'b11, 5'd5, 5'd6, 32'h108, 32'h10C);
        tick();
        drive_idle();
        set_wb(2'b11, 0, 1, 32'h11, 32'h22, 2'b10);
        tick();
        drive_idle();
        set_wb(2'b11, 2, 3, 32'h33, 32'h44, 2'b00);
        tick();
        drive_idle();
        bus.commit_ready = 1'b1;
        settle();
        n_cmp++; if (bus.commit_valid !== 2'b01 || e_cv !== 2'b01 || bus.commit_rd[4:0] !== 5'd1)
            begin n_bad++; $display("FAIL exc_older: got cv=%b rd=%0d want 01/1", bus.commit_valid, bus.commit_rd[4:0]); end
        tick();
        settle();
        n_cmp++; if (bus.commit_valid !== 2'b00 || bus.flush !== 1'b0)
            begin n_bad++; $display("FAIL exc_detect: got cv=%b flush=%b want 00/0", bus.commit_valid, bus.flush); end
        tick();
        set_alloc(2'b11, 5'd7, 5'd8, 32'h300, 32'h304);
        settle();
        n_cmp++; if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h104 || bus.flush_pc !== m_fpc)
            begin n_bad++; $display("FAIL exc_flush: got %b/%h want 1/104", bus.flush, bus.flush_pc); end
        n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL exc_count: got %0d want 0", bus.count); end
        tick();
        set_alloc(2'b11, 5'd9, 5'd10, 32'h400, 32'h404);
        settle();
        n_cmp++; if (bus.count !== 4'd0 || bus.flush !== 1'b0)
            begin n_bad++; $display("FAIL exc_drop: got %0d/%b want 0/0", bus.count, bus.flush); end
        n_cmp++; if (bus.alloc_tag !== 6'b001_000) begin n_bad++; $display("FAIL exc_restart: got %b want 001000", bus.alloc_tag); end
        tick();
        drive_idle();
        settle();
        n_cmp++; if (bus.count !== 4'd2) begin n_bad++; $display("FAIL exc_realloc: got %0d want 2", bus.count); end
    endtask

    task automatic test_wrap_ext_flush();
        int guard;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_alloc((c == 3) ? 2'b01 : 2'b11, 5'(10 + 2*c), 5'(11 + 2*c), 32'(16*c), 32'(16*c + 4));
            tick();
        end
        drive_idle();
        bus.commit_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_wb(2'b11, 2*c, 2*c + 1, 32'(c), 32'(c + 100), 2'b00);
            tick();
        end
        set_wb(2'b00, 0, 0, 32'h0, 32'h0, 2'b00);
        guard = 0;
        while (mq.size() != 0 && guard < 10) begin
            tick();
            guard++;
        end
        settle();
        n_cmp++; if (bus.count !== 4'd0 || e_count != 0) begin n_bad++; $display("FAIL wrap_drain: got %0d want 0", bus.count); end
        set_alloc(2'b11, 5'd17, 5'd20, 32'h700, 32'h704);
        settle();
        n_cmp++; if (bus.alloc_tag[2:0] !== 3'd7 || bus.alloc_tag[5:3] !== 3'd0 || e_tag[0] != 7)
            begin n_bad++; $display("FAIL wrap_tags: got %0d,%0d want 7,0", bus.alloc_tag[2:0], bus.alloc_tag[5:3]); end
        tick();
        drive_idle();
        set_wb(2'b11, 7, 0, 32'h77, 32'h88, 2'b00);
        tick();
        drive_idle();
        bus.commit_ready = 1'b1;
        settle();
        n_cmp++; if (bus.commit_valid !== 2'b11 || bus.commit_rd !== {5'd20, 5'd17} || bus.commit_rd !== {e_rd[1], e_rd[0]})
            begin n_bad++; $display("FAIL wrap_commit: got cv=%b rd=%h want 11 rd 20,17", bus.commit_valid, bus.commit_rd); end
        tick();
        set_alloc(2'b11, 5'd21, 5'd22, 32'h800, 32'h804);
        tick();
        settle();
        n_cmp++; if (bus.count !== 4'd2) begin n_bad++; $display("FAIL wrap_pre_flush: got %0d want 2", bus.count); end
        set_alloc(2'b11, 5'd23, 5'd24, 32'h900, 32'h904);
        bus.ext_flush = 1'b1;
        tick();
        drive_idle();
        settle();
        n_cmp++; if (bus.count !== 4'd0 || bus.flush !== 1'b1 || bus.flush_pc !== 32'h0)
            begin n_bad++; $display("FAIL ext_flush: got cnt=%0d flush=%b pc=%h want 0/1/0", bus.count, bus.flush, bus.flush_pc); end
        tick();
        set_alloc(2'b11, 5'd1, 5'd2, 32'h0, 32'h4);
        settle();
        n_cmp++; if (bus.flush !== 1'b0 || bus.alloc_tag !== 6'b001_000)
            begin n_bad++; $display("FAIL ext_restart: got flush=%b tags=%b want 0/001000", bus.flush, bus.alloc_tag); end
        tick();
        drive_idle();
    endtask

    task automatic test_random();
        int t0;
        int t1;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            set_alloc(2'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
            bus.commit_ready = ($urandom_range(3) != 0);
            bus.ext_flush    = ($urandom_range(40) == 0);
            t0 = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[$urandom_range(mq.size() - 1)].tag : $urandom_range(7);
            t1 = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[$urandom_range(mq.size() - 1)].tag : $urandom_range(7);
            if (t1 == t0) t1 = (t0 + 1) % 8;
            set_wb(2'($urandom), t0, t1, $urandom, $urandom,
                   {($urandom_range(15) == 0), ($urandom_range(15) == 0)});
            settle();
            n_cmp++; if (int'(bus.count) != e_count || bus.alloc_ready !== e_ready ||
                         bus.empty !== (e_count == 0) || bus.full !== (e_count == 8))
                begin n_bad++; $display("FAIL rand_occ@%0d: got cnt=%0d rdy=%b want %0d/%b", c, bus.count, bus.alloc_ready, e_count, e_ready); end
            n_cmp++; if (bus.commit_valid !== e_cv ||
                         (e_cv[0] && (bus.commit_rd[4:0] !== e_rd[0] || bus.commit_data[31:0] !== e_data[0])) ||
                         (e_cv[1] && (bus.commit_rd[9:5] !== e_rd[1] || bus.commit_data[63:32] !== e_data[1])))
                begin n_bad++; $display("FAIL rand_commit@%0d: got cv=%b rd=%h want cv=%b rd=%h,%h", c, bus.commit_valid, bus.commit_rd, e_cv, e_rd[1], e_rd[0]); end
            n_cmp++; if (bus.flush !== m_flush || (m_flush && bus.flush_pc !== m_fpc))
                begin n_bad++; $display("FAIL rand_flush@%0d: got %b/%h want %b/%h", c, bus.flush, bus.flush_pc, m_flush, m_fpc); end
            for (int i = 0; i < 2; i++) begin
                if (bus.alloc_valid[i]) begin
                    n_cmp++; if (bus.alloc_tag[i*3 +: 3] !== 3'(e_tag[i]))
                        begin n_bad++; $display("FAIL rand_tag%0d@%0d: got %0d want %0d", i, c, bus.alloc_tag[i*3 +: 3], e_tag[i]); end
                end
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        reset_   = 1'b0;
        next_tag = 0;
        m_flush  = 1'b0;
        m_fpc    = '0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_compaction();
        test_fill();
        test_ooo_retire();
        test_exception();
        test_wrap_ext_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
